// File: rtl/coherence_pkg.sv
// Shared coherence definitions: bus message encodings, controller state
// encoding and the width helper used to size index/select fields.
package coherence_pkg;

  // Bus message encodings shared by the L1 wrappers, mux_bus and responders
  localparam logic [3:0] NO_REQ     = 4'd0;
  localparam logic [3:0] R_REQ      = 4'd1;
  localparam logic [3:0] WB_REQ     = 4'd2;
  localparam logic [3:0] FLUSH      = 4'd3;
  localparam logic [3:0] INVALIDATE = 4'd4;
  localparam logic [3:0] INV_ACK    = 4'd5;
  localparam logic [3:0] WB_ACK     = 4'd6;
  localparam logic [3:0] MEM_RESP   = 4'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Ceiling log2, never smaller than 1 so a degenerate field still has a bit
  function automatic int log2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res < 1) begin
      return 1;
    end else begin
      return res;
    end
  endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational arbiter: rotates the request vector so the search starts at
// ptr, picks the lowest set bit, then maps the offset back to a port index.
module rr_priority_arbiter
  import coherence_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = 1,
  localparam int PW   = log2(N),
  localparam int IW   = log2(N + 1)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   win_s;
  logic [PW-1:0]  base_s;
  logic [IW-1:0]  offset_s;
  logic [IW:0]    sum_s;

  // Fixed priority always searches from port 0; round-robin from the pointer
  always_comb begin
    if (MODE == 0) begin
      base_s = '0;
    end else begin
      base_s = ptr;
    end
  end

  assign dbl_s = {req, req};
  assign win_s = N'(dbl_s >> base_s);
  assign any   = |req;

  // Lowest set bit of the rotated window; scanning downward leaves the lowest
  always_comb begin
    offset_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      offset_s = win_s[i] ? IW'(i) : offset_s;
    end
  end

  // Undo the rotation: base + offset, wrapped once modulo N
  always_comb begin
    sum_s = (IW + 1)'(base_s) + (IW + 1)'(offset_s);
    if (sum_s >= (IW + 1)'(N)) begin
      grant_idx = IW'(sum_s - (IW + 1)'(N));
    end else begin
      grant_idx = IW'(sum_s);
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping-bus controller: arbitrates L1 ports, hands the bus to the
// responder while it answers, releases for one cycle, and guards every
// transaction with a watchdog that raises a sticky error.
module snoop_bus_controller
  import coherence_pkg::*;
#(
  parameter  int MSG_BITS       = 4,
  parameter  int NUM_CACHES     = 4,
  parameter  int ARB_MODE       = 1,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_BITS       = 16,
  localparam int CW             = log2(NUM_CACHES + 1),
  localparam int PW             = log2(NUM_CACHES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CACHES*MSG_BITS-1:0] cache2mem_msg,
  input  logic [MSG_BITS-1:0]            mem2controller_msg,
  input  logic [MSG_BITS-1:0]            bus_msg,
  output logic [CW-1:0]                  bus_control,
  output logic                           bus_en,
  output logic [NUM_CACHES-1:0]          curr_master,
  output logic                           req_ready,
  output logic                           timeout_err,
  output logic [CW-1:0]                  err_port
);

  localparam logic [MSG_BITS-1:0] NO_REQ_M = MSG_BITS'(NO_REQ);
  localparam logic [CW-1:0]       RESP_SEL = CW'(NUM_CACHES);

  state_e                  state_r, state_base_s, state_nxt_s;
  logic [CW-1:0]           winner_r, winner_nxt_s, arb_idx_s;
  logic [PW-1:0]           rr_ptr_r;
  logic [CNT_BITS-1:0]     wd_r, wd_inc_s;
  logic [NUM_CACHES-1:0]   req_s, master_dec_s, master_d_s;
  logic                    arb_any_s, resp_s, win_req_s, wd_expire_s, timeout_hit_s;
  logic [CW-1:0]           ctrl_d_s;
  logic                    en_d_s, rdy_d_s;
  logic [CW-1:0]           bus_control_r, err_port_r;
  logic [NUM_CACHES-1:0]   curr_master_r;
  logic                    bus_en_r, req_ready_r, timeout_err_r;
  logic                    bus_msg_unused_s;

  // bus_msg is observation-only; kept so the port list matches the old controller
  assign bus_msg_unused_s = ^bus_msg;

  rr_priority_arbiter #(.N(NUM_CACHES), .MODE(ARB_MODE)) u_arb (
    .req       (req_s),
    .ptr       (rr_ptr_r),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  // Request decode per port, plus the granted master's own request bit
  always_comb begin
    req_s     = '0;
    win_req_s = 1'b0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      req_s[i]  = (cache2mem_msg[i*MSG_BITS +: MSG_BITS] != NO_REQ_M);
      win_req_s = (winner_r == CW'(i)) ? req_s[i] : win_req_s;
    end
  end

  assign resp_s       = (mem2controller_msg != NO_REQ_M);
  assign winner_nxt_s = (state_r == IDLE && arb_any_s) ? arb_idx_s : winner_r;
  assign wd_inc_s     = wd_r + CNT_BITS'(1);
  assign wd_expire_s  = (TIMEOUT_CYCLES != 0) &&
                        (wd_inc_s == CNT_BITS'(TIMEOUT_CYCLES)) &&
                        (state_r == GRANT || state_r == RESP);

  // Next state; a normal release beats the watchdog, otherwise expiry forces RELEASE
  always_comb begin
    state_base_s  = state_r;
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_any_s) state_base_s = GRANT;
        else           state_base_s = IDLE;
      end
      GRANT: begin
        if (resp_s)          state_base_s = RESP;
        else if (!win_req_s) state_base_s = RELEASE;
        else                 state_base_s = GRANT;
      end
      RESP: begin
        if (!resp_s && !win_req_s) state_base_s = RELEASE;
        else if (!resp_s)          state_base_s = GRANT;
        else                       state_base_s = RESP;
      end
      RELEASE: state_base_s = IDLE;
      default: state_base_s = IDLE;
    endcase
    if (wd_expire_s && state_base_s != RELEASE) begin
      state_nxt_s   = RELEASE;
      timeout_hit_s = 1'b1;
    end else begin
      state_nxt_s   = state_base_s;
      timeout_hit_s = 1'b0;
    end
  end

  // One-hot decode of the master that will own the bus next cycle
  always_comb begin
    master_dec_s = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      master_dec_s[i] = (winner_nxt_s == CW'(i));
    end
  end

  // Output values for the upcoming state, so the registered outputs track it
  always_comb begin
    ctrl_d_s   = RESP_SEL;
    en_d_s     = 1'b0;
    master_d_s = '0;
    rdy_d_s    = 1'b0;
    case (state_nxt_s)
      GRANT: begin
        ctrl_d_s   = winner_nxt_s;
        en_d_s     = 1'b1;
        master_d_s = master_dec_s;
        rdy_d_s    = 1'b1;
      end
      RESP: begin
        ctrl_d_s   = RESP_SEL;
        en_d_s     = 1'b1;
        master_d_s = master_dec_s;
        rdy_d_s    = 1'b0;
      end
      default: begin
        ctrl_d_s   = RESP_SEL;
        en_d_s     = 1'b0;
        master_d_s = '0;
        rdy_d_s    = 1'b0;
      end
    endcase
  end

  // FSM state, latched winner, round-robin pointer and watchdog counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      winner_r <= '0;
      rr_ptr_r <= '0;
      wd_r     <= '0;
    end else begin
      state_r  <= state_nxt_s;
      winner_r <= winner_nxt_s;
      if (ARB_MODE == 1 && state_r == RELEASE) begin
        if (winner_r == CW'(NUM_CACHES - 1)) rr_ptr_r <= '0;
        else                                 rr_ptr_r <= PW'(winner_r + CW'(1));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (state_r == IDLE && state_nxt_s == GRANT) begin
        wd_r <= '0;
      end else if (state_r == GRANT || state_r == RESP) begin
        wd_r <= wd_inc_s;
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  // Sticky timeout flag; only the first offender's index is recorded
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_err_r <= 1'b0;
      err_port_r    <= '0;
    end else if (timeout_hit_s && !timeout_err_r) begin
      timeout_err_r <= 1'b1;
      err_port_r    <= winner_r;
    end else begin
      timeout_err_r <= timeout_err_r;
      err_port_r    <= err_port_r;
    end
  end

  // Registered bus-control outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_control_r <= RESP_SEL;
      bus_en_r      <= 1'b0;
      curr_master_r <= '0;
      req_ready_r   <= 1'b0;
    end else begin
      bus_control_r <= ctrl_d_s;
      bus_en_r      <= en_d_s;
      curr_master_r <= master_d_s;
      req_ready_r   <= rdy_d_s;
    end
  end

  assign bus_control = bus_control_r;
  assign bus_en      = bus_en_r;
  assign curr_master = curr_master_r;
  assign req_ready   = req_ready_r;
  assign timeout_err = timeout_err_r;
  assign err_port    = err_port_r;

endmodule
